ram_stream_reader: RTL and testbench

Read initiator for the single-read/single-write RAM port (arvalid/raddr → rdata/rvalid). It accepts a burst command (start address, word count) and issues one read per cycle to the RAM read port. Returned words go into an internal credit-controlled FIFO and leave on a valid/ready stream, with the last word marked. It sits between RAM blocks and stream consumers, so a downstream stage can apply backpressure without losing in-flight reads.

---
 rtl/ram_stream_reader_if.sv | 30 +++
 rtl/ram_stream_reader.sv | 154 +++++++++++++++
 tb/tb_ram_stream_reader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_stream_reader_if.sv
// rtl/ram_stream_reader_if.sv - command, RAM read port and output stream bundle for ram_stream_reader
// master = reader side, slave = the agent driving commands, RAM data and stream ready.
interface ram_stream_reader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  arvalid;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, rdata, rvalid, m_ready,
    output cmd_ready, arvalid, raddr, m_valid, m_data, m_last
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, rdata, rvalid, m_ready,
    input  cmd_ready, arvalid, raddr, m_valid, m_data, m_last
  );
endinterface

// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - burst RAM read initiator with credit-controlled output FIFO
// Optional backpressure counter is built only when RAM_READER_STALL_CNT_EN is defined.
module ram_stream_reader #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int RDELAY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  ram_stream_reader_if.master bus,
  output logic                o_busy,
  output logic                o_done,
  output logic [31:0]         o_stall_cnt
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_cmd_ready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_arvalid;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] w_raddr_next;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_issue_cnt;
  logic [LEN_WIDTH-1:0]  r_out_cnt;
  logic [LEN_WIDTH-1:0]  w_issue_next;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count_next;
  logic [CW-1:0]         w_used_next;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_m_valid;
  logic                  w_last_out;
  logic                  w_done_next;
  logic                  w_arvalid_next;
  logic                  w_outst_next;

  assign w_m_valid    = (r_count != '0);
  assign w_pop        = w_m_valid && bus.m_ready;
  assign w_push       = bus.rvalid && (r_state != IDLE);
  assign w_accept     = bus.cmd_valid && r_cmd_ready;
  assign w_last_out   = (r_out_cnt == r_len - LEN_WIDTH'(1));
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
  // Credits are predicted one cycle ahead because arvalid is a register.
  assign w_outst_next = (RDELAY != 0) && r_arvalid;
  assign w_used_next  = w_count_next + CW'(w_outst_next);
  assign w_issue_next = w_accept ? '0 : r_issue_cnt + LEN_WIDTH'(r_arvalid);
  assign w_raddr_next = (w_accept ? bus.cmd_addr : r_base) + ADDR_WIDTH'(w_issue_next);

  always_comb begin
    w_state_next   = r_state;
    w_done_next    = 1'b0;
    w_arvalid_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (bus.cmd_len != '0) w_state_next = ISSUE;
          else                   w_done_next  = 1'b1;
        end
      end
      ISSUE: begin
        if (w_issue_next == r_len) w_state_next = DRAIN;
      end
      DRAIN: begin
        if (w_pop && w_last_out) begin
          w_state_next = IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
    w_arvalid_next = (w_state_next == ISSUE) && (w_used_next < CW'(FIFO_DEPTH));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_arvalid   <= 1'b0;
      r_raddr     <= '0;
      r_base      <= '0;
      r_len       <= '0;
      r_issue_cnt <= '0;
      r_out_cnt   <= '0;
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
    end else begin
      r_cmd_ready <= (w_state_next == IDLE);
      r_busy      <= (w_state_next != IDLE);
      r_done      <= w_done_next;
      r_arvalid   <= w_arvalid_next;
      r_issue_cnt <= w_issue_next;
      r_count     <= w_count_next;
      if (w_accept) begin
        r_base <= bus.cmd_addr;
        r_len  <= bus.cmd_len;
      end
      if (w_accept)   r_out_cnt <= '0;
      else if (w_pop) r_out_cnt <= r_out_cnt + LEN_WIDTH'(1);
      if (w_state_next == ISSUE) r_raddr <= w_raddr_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst) r_mem[r_wr_ptr] <= bus.rdata;
  end

`ifdef RAM_READER_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || w_accept) begin
      r_stall_cnt <= '0;
    end else if (w_m_valid && !bus.m_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_stall_cnt = 32'd0;
`endif

  // A read request must not escape while reset is being applied.
  assign bus.arvalid   = r_arvalid && !i_rst;
  assign bus.raddr     = r_raddr;
  assign bus.cmd_ready = r_cmd_ready;
  assign bus.m_valid   = w_m_valid;
  assign bus.m_data    = r_mem[r_rd_ptr];
  assign bus.m_last    = w_m_valid && w_last_out;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb/tb_ram_stream_reader.sv - directed self-checking bench for ram_stream_reader
// dut_a: RDELAY=0, 4-bit addresses; dut_b: RDELAY=1, 32-bit addresses; both FIFO_DEPTH=4.
module tb_ram_stream_reader;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_stream_reader_if #(.ADDR_WIDTH(4),  .DATA_WIDTH(32), .LEN_WIDTH(16)) bus_a ();
  ram_stream_reader_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(16)) bus_b ();
  logic        busy_a, done_a, busy_b, done_b;
  logic [31:0] stall_a, stall_b;

  ram_stream_reader #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .LEN_WIDTH(16), .RDELAY(0), .FIFO_DEPTH(4)) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(bus_a), .o_busy(busy_a), .o_done(done_a), .o_stall_cnt(stall_a)
  );
  ram_stream_reader #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(16), .RDELAY(1), .FIFO_DEPTH(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(bus_b), .o_busy(busy_b), .o_done(done_b), .o_stall_cnt(stall_b)
  );

  logic [31:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 32'h100 + 32'(i);

  assign bus_a.rdata  = mem[bus_a.raddr];
  assign bus_a.rvalid = bus_a.arvalid;
  always @(posedge clk) begin
    bus_b.rvalid <= bus_b.arvalid;
    bus_b.rdata  <= mem[bus_b.raddr[3:0]];
  end

  int          acc_a, acc_b, done_cyc_a, done_cyc_b;
  int          done_n_a = 0, done_n_b = 0;
  int          used_b = 0, cred_err_b = 0, stall_exp_b = 0;
  bit          done_busy_a, done_busy_b;
  logic [31:0] wq_a[$], wq_b[$], ra_a[$], ra_b[$];
  int          wc_a[$], wc_b[$];
  bit          wl_a[$], wl_b[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus_a.cmd_valid && bus_a.cmd_ready) acc_a = cyc;
      if (bus_a.arvalid) ra_a.push_back(32'(bus_a.raddr));
      if (bus_a.m_valid && bus_a.m_ready) begin
        wq_a.push_back(bus_a.m_data); wc_a.push_back(cyc); wl_a.push_back(bus_a.m_last);
      end
      if (done_a) begin done_cyc_a = cyc; done_busy_a = busy_a; done_n_a++; end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      used_b = 0; stall_exp_b = 0;
    end else begin
      if (bus_b.cmd_valid && bus_b.cmd_ready) begin acc_b = cyc; stall_exp_b = 0; end
      if (bus_b.arvalid) ra_b.push_back(bus_b.raddr);
      if (bus_b.arvalid && used_b >= 4) cred_err_b++;
      if (bus_b.m_valid && !bus_b.m_ready) stall_exp_b++;
      if (bus_b.m_valid && bus_b.m_ready) begin
        wq_b.push_back(bus_b.m_data); wc_b.push_back(cyc); wl_b.push_back(bus_b.m_last);
      end
      if (done_b) begin done_cyc_b = cyc; done_busy_b = busy_b; done_n_b++; end
      used_b = used_b + int'(bus_b.arvalid) - int'(bus_b.m_valid && bus_b.m_ready);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wq_a.delete(); wc_a.delete(); wl_a.delete(); ra_a.delete();
    wq_b.delete(); wc_b.delete(); wl_b.delete(); ra_b.delete();
    cred_err_b = 0;
  endtask

  task automatic set_ready(input bit b, input bit v);
    if (b) bus_b.m_ready = v;
    else   bus_a.m_ready = v;
  endtask

  task automatic send_cmd(input bit b, input logic [31:0] addr, input logic [15:0] len);
    if (b) begin bus_b.cmd_valid = 1'b1; bus_b.cmd_addr = addr; bus_b.cmd_len = len; end
    else begin bus_a.cmd_valid = 1'b1; bus_a.cmd_addr = addr[3:0]; bus_a.cmd_len = len; end
    tick();
    bus_a.cmd_valid = 1'b0;
    bus_b.cmd_valid = 1'b0;
  endtask

  task automatic run_until_done(input bit b, input bit toggle, input int budget, output bit timed_out);
    int start_n;
    start_n   = b ? done_n_b : done_n_a;
    timed_out = 1'b1;
    for (int k = 0; k < budget; k++) begin
      if (toggle) set_ready(b, (k % 4) == 0);
      tick();
      if ((b ? done_n_b : done_n_a) != start_n) begin timed_out = 1'b0; break; end
    end
    if (toggle) set_ready(b, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (bus_a.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", bus_a.cmd_ready); end
    checks++; if (bus_a.arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b want 0", bus_a.arvalid); end
    checks++; if (bus_a.raddr !== 4'd0) begin errors++; $display("FAIL reset_raddr: got %0h want 0", bus_a.raddr); end
    checks++; if (bus_a.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", bus_a.m_valid); end
    checks++; if (bus_a.m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b want 0", bus_a.m_last); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_a); end
    checks++; if (stall_a !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_a); end
    checks++; if (bus_b.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_b_cmd_ready: got %b want 1", bus_b.cmd_ready); end
    checks++; if (bus_b.m_valid !== 1'b0) begin errors++; $display("FAIL reset_b_m_valid: got %b want 0", bus_b.m_valid); end
  endtask

  task automatic test_rdelay0();
    bit to;
    clear_mon(); set_ready(0, 1'b1);
    send_cmd(0, 32'd4, 16'd4);
    run_until_done(0, 1'b0, 40, to);
    checks++; if (to) begin errors++; $display("FAIL rd0_timeout: done not seen within 40 cycles"); end
    checks++; if (wq_a.size() != 4) begin errors++; $display("FAIL rd0_count: got %0d words want 4", wq_a.size()); end
    for (int i = 0; i < 4 && i < wq_a.size(); i++) begin
      checks++; if (wq_a[i] !== 32'h104 + 32'(i)) begin errors++; $display("FAIL rd0_data[%0d]: got %h want %h", i, wq_a[i], 32'h104 + 32'(i)); end
      checks++; if (wc_a[i] != acc_a + 2 + i) begin errors++; $display("FAIL rd0_cycle[%0d]: got %0d want %0d", i, wc_a[i], acc_a + 2 + i); end
      checks++; if (wl_a[i] !== (i == 3)) begin errors++; $display("FAIL rd0_last[%0d]: got %b want %b", i, wl_a[i], i == 3); end
    end
    checks++; if (done_cyc_a != acc_a + 6) begin errors++; $display("FAIL rd0_done_cycle: got %0d want %0d", done_cyc_a, acc_a + 6); end
    checks++; if (done_busy_a !== 1'b0) begin errors++; $display("FAIL rd0_busy_at_done: got %b want 0", done_busy_a); end
  endtask

  task automatic test_rdelay1();
    bit to;
    clear_mon(); set_ready(1, 1'b1);
    send_cmd(1, 32'd0, 16'd8);
    run_until_done(1, 1'b0, 60, to);
    checks++; if (to) begin errors++; $display("FAIL rd1_timeout: done not seen within 60 cycles"); end
    checks++; if (wq_b.size() != 8) begin errors++; $display("FAIL rd1_count: got %0d words want 8", wq_b.size()); end
    for (int i = 0; i < 8 && i < wq_b.size(); i++) begin
      checks++; if (wq_b[i] !== 32'h100 + 32'(i)) begin errors++; $display("FAIL rd1_data[%0d]: got %h want %h", i, wq_b[i], 32'h100 + 32'(i)); end
      checks++; if (wc_b[i] != acc_b + 3 + i) begin errors++; $display("FAIL rd1_cycle[%0d]: got %0d want %0d", i, wc_b[i], acc_b + 3 + i); end
      checks++; if (wl_b[i] !== (i == 7)) begin errors++; $display("FAIL rd1_last[%0d]: got %b want %b", i, wl_b[i], i == 7); end
    end
    checks++; if (done_cyc_b != acc_b + 11) begin errors++; $display("FAIL rd1_done_cycle: got %0d want %0d", done_cyc_b, acc_b + 11); end
  endtask

  task automatic test_backpressure();
    bit to;
    int exp_stall;
    clear_mon(); set_ready(1, 1'b0);
    send_cmd(1, 32'd0, 16'd16);
    run_until_done(1, 1'b1, 300, to);
    checks++; if (to) begin errors++; $display("FAIL bp_timeout: done not seen within 300 cycles"); end
    checks++; if (wq_b.size() != 16) begin errors++; $display("FAIL bp_count: got %0d words want 16", wq_b.size()); end
    for (int i = 0; i < 16 && i < wq_b.size(); i++) begin
      checks++; if (wq_b[i] !== 32'h100 + 32'(i)) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, wq_b[i], 32'h100 + 32'(i)); end
      checks++; if (wl_b[i] !== (i == 15)) begin errors++; $display("FAIL bp_last[%0d]: got %b want %b", i, wl_b[i], i == 15); end
    end
    checks++; if (ra_b.size() != 16) begin errors++; $display("FAIL bp_reads: got %0d reads want 16", ra_b.size()); end
    checks++; if (cred_err_b != 0) begin errors++; $display("FAIL bp_credit: arvalid with 4 credits used %0d times want 0", cred_err_b); end
`ifdef RAM_READER_STALL_CNT_EN
    exp_stall = stall_exp_b;
`else
    exp_stall = 0;
`endif
    checks++; if (stall_b !== 32'(exp_stall)) begin errors++; $display("FAIL bp_stall_cnt: got %0d want %0d", stall_b, exp_stall); end
  endtask

  task automatic test_wrap();
    bit to;
    logic [31:0] exp_addr [4];
    exp_addr[0] = 32'd14; exp_addr[1] = 32'd15; exp_addr[2] = 32'd0; exp_addr[3] = 32'd1;
    clear_mon(); set_ready(0, 1'b1);
    send_cmd(0, 32'd14, 16'd4);
    run_until_done(0, 1'b0, 40, to);
    checks++; if (to) begin errors++; $display("FAIL wrap_timeout: done not seen within 40 cycles"); end
    checks++; if (ra_a.size() != 4) begin errors++; $display("FAIL wrap_reads: got %0d reads want 4", ra_a.size()); end
    for (int i = 0; i < 4 && i < ra_a.size() && i < wq_a.size(); i++) begin
      checks++; if (ra_a[i] !== exp_addr[i]) begin errors++; $display("FAIL wrap_raddr[%0d]: got %0d want %0d", i, ra_a[i], exp_addr[i]); end
      checks++; if (wq_a[i] !== 32'h100 + exp_addr[i]) begin errors++; $display("FAIL wrap_data[%0d]: got %h want %h", i, wq_a[i], 32'h100 + exp_addr[i]); end
    end
  endtask

  task automatic test_zero_len();
    bit to;
    clear_mon(); set_ready(0, 1'b1);
    send_cmd(0, 32'd3, 16'd0);
    run_until_done(0, 1'b0, 10, to);
    tick(); tick(); tick();
    checks++; if (to) begin errors++; $display("FAIL zero_timeout: done not seen within 10 cycles"); end
    checks++; if (done_cyc_a != acc_a + 1) begin errors++; $display("FAIL zero_done_cycle: got %0d want %0d", done_cyc_a, acc_a + 1); end
    checks++; if (ra_a.size() != 0) begin errors++; $display("FAIL zero_reads: got %0d reads want 0", ra_a.size()); end
    checks++; if (wq_a.size() != 0) begin errors++; $display("FAIL zero_words: got %0d words want 0", wq_a.size()); end
    checks++; if (done_busy_a !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", done_busy_a); end
  endtask

  task automatic test_reset_mid();
    bit to;
    clear_mon(); set_ready(1, 1'b1);
    send_cmd(1, 32'd4, 16'd8);
    for (int k = 0; k < 50; k++) begin
      if (wq_b.size() >= 3) break;
      tick();
    end
    set_ready(1, 1'b0);
    for (int k = 0; k < 6; k++) tick();
    checks++; if (wq_b.size() != 3) begin errors++; $display("FAIL mid_words_before: got %0d want 3", wq_b.size()); end
    checks++; if (used_b != 4) begin errors++; $display("FAIL mid_fifo_full: credits used %0d want 4", used_b); end
    checks++; if (bus_b.m_valid !== 1'b1) begin errors++; $display("FAIL mid_m_valid_before: got %b want 1", bus_b.m_valid); end
    rst = 1'b1;
    #1;
    checks++; if (bus_b.arvalid !== 1'b0) begin errors++; $display("FAIL mid_arvalid_in_reset: got %b want 0", bus_b.arvalid); end
    tick();
    checks++; if (bus_b.m_valid !== 1'b0) begin errors++; $display("FAIL mid_m_valid: got %b want 0", bus_b.m_valid); end
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy_b); end
    checks++; if (bus_b.cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_cmd_ready: got %b want 1", bus_b.cmd_ready); end
    checks++; if (stall_b !== 32'd0) begin errors++; $display("FAIL mid_stall_cnt: got %0d want 0", stall_b); end
    rst = 1'b0;
    clear_mon(); set_ready(1, 1'b1);
    send_cmd(1, 32'd0, 16'd2);
    run_until_done(1, 1'b0, 30, to);
    tick(); tick(); tick();
    checks++; if (to) begin errors++; $display("FAIL mid_timeout: done not seen within 30 cycles"); end
    checks++; if (wq_b.size() != 2) begin errors++; $display("FAIL mid_words_after: got %0d want 2", wq_b.size()); end
    for (int i = 0; i < 2 && i < wq_b.size(); i++) begin
      checks++; if (wq_b[i] !== 32'h100 + 32'(i)) begin errors++; $display("FAIL mid_data[%0d]: got %h want %h", i, wq_b[i], 32'h100 + 32'(i)); end
      checks++; if (wl_b[i] !== (i == 1)) begin errors++; $display("FAIL mid_last[%0d]: got %b want %b", i, wl_b[i], i == 1); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus_a.cmd_valid = 1'b0; bus_a.cmd_addr = '0; bus_a.cmd_len = '0; bus_a.m_ready = 1'b0;
    bus_b.cmd_valid = 1'b0; bus_b.cmd_addr = '0; bus_b.cmd_len = '0; bus_b.m_ready = 1'b0;
    test_reset();
    test_rdelay0();
    test_rdelay1();
    test_backpressure();
    test_wrap();
    test_zero_len();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
